// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM block model: width codes, config bit
// positions, lane shift helper and clear FSM states.
package bram_pkg;

   localparam logic [1:0] W32  = 2'b00;
   localparam logic [1:0] W16  = 2'b01;
   localparam logic [1:0] W8   = 2'b10;
   localparam logic [1:0] WOFF = 2'b11;

   localparam int CFG_WEN  = 4;
   localparam int CFG_OREG = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   // Entry-to-word shift for a width code; a disabled port is gated elsewhere.
   function automatic logic [1:0] lane_shift(input logic [1:0] code);
      case (code)
         W16:     lane_shift = 2'd1;
         W8:      lane_shift = 2'd2;
         default: lane_shift = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/bram_block_model_if.sv
// User-design port of one BRAM slot: addresses, write data and config in,
// read data and clear status back.
interface bram_block_model_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [7:0]        cfg;
   logic [DATA_W-1:0] rd_data;
   logic              busy;

   modport master (output rd_addr, wr_addr, wr_data, cfg, input rd_data, busy);
   modport slave  (input rd_addr, wr_addr, wr_data, cfg, output rd_data, busy);
endinterface

// File: rtl/bram_lane_unit.sv
// Lane logic: merges narrow write data into a word and extracts a
// zero-extended lane on read.
module bram_lane_unit
   import bram_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wr_data,
   input  logic [1:0]  wr_w,
   input  logic [1:0]  wr_lane,
   output logic [31:0] new_word,
   input  logic [31:0] rd_word,
   input  logic [1:0]  rd_w,
   input  logic [1:0]  rd_lane,
   output logic [31:0] rd_out
);

   always_comb begin
      new_word = old_word;
      case (wr_w)
         W32:     new_word = wr_data;
         W16:     new_word[{wr_lane[0], 4'b0} +: 16] = wr_data[15:0];
         W8:      new_word[{wr_lane, 3'b0} +: 8]     = wr_data[7:0];
         default: ;
      endcase

      rd_out = '0;
      case (rd_w)
         W32:     rd_out        = rd_word;
         W16:     rd_out[15:0]  = rd_word[{rd_lane[0], 4'b0} +: 16];
         W8:      rd_out[7:0]   = rd_word[{rd_lane, 3'b0} +: 8];
         default: ;
      endcase
   end

endmodule

// File: rtl/bram_block_model.sv
// Cycle model of the 256 x 32 fabric BRAM: config decode, lane merge/extract,
// read-first array, optional output register and post-reset zero fill.
module bram_block_model
   import bram_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic clk,
   input logic rst,
   bram_block_model_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   clr_state_e        state;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        ws, rs;
   logic [ADDR_W-1:0] wa, ra;
   logic [DATA_W-1:0] new_word, rd_ext, r1, r2;
   logic              oreg_q, we;
   logic              unused_cfg;

   assign ws = lane_shift(bus.cfg[1:0]);
   assign rs = lane_shift(bus.cfg[3:2]);
   assign wa = bus.wr_addr >> ws;
   assign ra = bus.rd_addr >> rs;
   assign we = bus.cfg[CFG_WEN] && (bus.cfg[1:0] != WOFF) && (state == IDLE) && !rst;
   assign unused_cfg = ^bus.cfg[7:6];

   // Raw low address bits serve as the lane; the unit ignores bits a mode does not use.
   bram_lane_unit u_lane (
      .old_word (mem[wa]),
      .wr_data  (bus.wr_data),
      .wr_w     (bus.cfg[1:0]),
      .wr_lane  (bus.wr_addr[1:0]),
      .new_word (new_word),
      .rd_word  (mem[ra]),
      .rd_w     (bus.cfg[3:2]),
      .rd_lane  (bus.rd_addr[1:0]),
      .rd_out   (rd_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR_ON_RESET ? CLEAR : IDLE;
         idx   <= '0;
      end else if (state == CLEAR) begin
         idx <= idx + 1'b1;
         if (idx == '1) state <= IDLE;
      end
   end

   // Array has no reset; the clear sequence and user writes share one port.
   always_ff @(posedge clk) begin
      if (!rst && state == CLEAR) mem[idx] <= '0;
      else if (we)                mem[wa]  <= new_word;
   end

   // Stage 1 reads old contents (read-first); stage 2 always follows stage 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1     <= '0;
         r2     <= '0;
         oreg_q <= 1'b0;
      end else begin
         r1     <= (state == CLEAR) ? '0 : rd_ext;
         r2     <= r1;
         oreg_q <= bus.cfg[CFG_OREG];
      end
   end

   assign bus.busy    = (state == CLEAR);
   assign bus.rd_data = (state == CLEAR) ? '0 : (oreg_q ? r2 : r1);

endmodule

// File: tb/tb_bram_block_model.sv
// Directed bench for bram_block_model with a queued scoreboard of read results.
module tb_bram_block_model;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   typedef struct {
      int          due;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m [256];

   bram_block_model_if bus ();

   bram_block_model #(.ADDR_W(8), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: compare every entry whose due edge has just passed.
   always @(posedge clk) begin
      cyc++;
      #1;
      for (int i = 0; i < q.size();) begin
         if (q[i].due <= cyc) begin
            chk(q[i].tag, bus.rd_data, q[i].exp);
            q.delete(i);
         end else i++;
      end
   end

   function automatic logic [31:0] mread(input logic [7:0] a, input logic [1:0] w);
      logic [31:0] wd;
      case (w)
         2'd0: return m[a];
         2'd1: begin wd = m[a >> 1]; return a[0] ? {16'h0, wd[31:16]} : {16'h0, wd[15:0]}; end
         2'd2: begin wd = m[a >> 2]; return (wd >> (8 * a[1:0])) & 32'hFF; end
         default: return 32'h0;
      endcase
   endfunction

   task automatic mwrite(input logic [7:0] a, input logic [31:0] d, input logic [1:0] w);
      logic [31:0] wd;
      case (w)
         2'd0: m[a] = d;
         2'd1: begin
            wd = m[a >> 1];
            if (a[0]) wd[31:16] = d[15:0]; else wd[15:0] = d[15:0];
            m[a >> 1] = wd;
         end
         2'd2: begin
            wd = m[a >> 2];
            wd = (wd & ~(32'hFF << (8 * a[1:0]))) | ({24'h0, d[7:0]} << (8 * a[1:0]));
            m[a >> 2] = wd;
         end
         default: ;
      endcase
   endtask

   // One cycle of stimulus; the expected read is taken from the model before the write.
   task automatic op(input logic [7:0] ra, input logic [7:0] wa, input logic [31:0] wd,
                     input logic [7:0] c, input bit chk_rd, input string tag);
      exp_t e;
      @(negedge clk);
      bus.rd_addr = ra;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.cfg     = c;
      if (chk_rd) begin
         e.due = cyc + (c[5] ? 2 : 1);
         e.exp = mread(ra, c[3:2]);
         e.tag = tag;
         q.push_back(e);
      end
      if (c[4] && c[1:0] != 2'b11) mwrite(wa, wd, c[1:0]);
   endtask

   task automatic drain();
      @(negedge clk);
      bus.cfg = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   // Called at a negedge right after a reset edge: release and time the clear,
   // while hammering writes that must all be dropped.
   task automatic release_and_count(input string tag);
      int   n;
      logic nz;
      n  = 0;
      nz = 1'b0;
      rst     = 1'b0;
      bus.cfg = 8'h10;
      while (bus.busy === 1'b1 && n < 400) begin
         if (bus.rd_data !== 32'h0) nz = 1'b1;
         bus.wr_addr = n[7:0];
         bus.wr_data = 32'hFFFF_FFFF;
         n++;
         @(negedge clk);
      end
      bus.cfg = 8'h00;
      chk({tag, "_busy_len"}, n, 256);
      chk({tag, "_rd_zero"}, {31'h0, nz}, 32'h0);
      for (int i = 0; i < 256; i++) m[i] = 32'h0;
   endtask

   initial begin
      logic [7:0] a;
      rst         = 1'b1;
      bus.rd_addr = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.cfg     = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_rd_data", bus.rd_data, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h1);
      release_and_count("clr1");

      op(8'h00, 8'h00, 32'h0, 8'h00, 1, "post_clr_00");
      op(8'h7F, 8'h00, 32'h0, 8'h00, 1, "post_clr_7f");
      op(8'hFF, 8'h00, 32'h0, 8'h00, 1, "post_clr_ff");

      for (int n = 0; n <= 256; n++) begin
         a = n[7:0];
         op(a - 8'd1, a, {4{a}}, 8'h10, 1, $sformatf("cnt_%0d", n));
      end

      op(8'h00, 8'h20, 32'hDEAD_BEEF, 8'h10, 0, "");
      op(8'h20, 8'h20, 32'h1234_5678, 8'h10, 1, "rd_first_old");
      op(8'h20, 8'h00, 32'h0,         8'h00, 1, "rd_first_new");
      drain();

      // Reset again and again mid-clear at index 100.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      release_and_count("clr2");
      for (int i = 0; i < 256; i++) begin
         a = i[7:0];
         op(a, 8'h00, 32'h0, 8'h00, 1, $sformatf("clr2_word_%0d", i));
      end

      op(8'h00, 8'h05, 32'h0000_00AB, 8'h12, 0, "");
      op(8'h01, 8'h00, 32'h0,         8'h00, 1, "nar_rd32_w1");
      op(8'h02, 8'h00, 32'h0,         8'h04, 1, "nar_rd16_e2");
      op(8'h03, 8'h00, 32'h0,         8'h04, 1, "nar_rd16_e3");
      op(8'h05, 8'h00, 32'h0,         8'h08, 1, "nar_rd8_e5");
      op(8'h04, 8'h00, 32'h0,         8'h08, 1, "nar_rd8_e4");
      op(8'h00, 8'h03, 32'hCAFE_1234, 8'h11, 0, "");
      op(8'h01, 8'h00, 32'h0,         8'h00, 1, "nar_rd32_w16");
      op(8'h00, 8'h01, 32'hFFFF_FFFF, 8'h13, 0, "");
      op(8'h01, 8'h00, 32'h0,         8'h00, 1, "wr_off_keep");
      op(8'h01, 8'h00, 32'h0,         8'h0C, 1, "rd_off_zero");

      op(8'h00, 8'h03, 32'h3333_3333, 8'h10, 0, "");
      op(8'h00, 8'h07, 32'h7777_7777, 8'h10, 0, "");
      op(8'h03, 8'h03, 32'h0000_0055, 8'h00, 1, "wen_off_old");
      op(8'h03, 8'h00, 32'h0,         8'h00, 1, "wen_off_keep");

      op(8'h00, 8'h00, 32'h0, 8'h20, 0, "");
      op(8'h03, 8'h80, 32'h8080_8080, 8'h30, 1, "oreg_rd3");
      op(8'h07, 8'h81, 32'h8181_8181, 8'h30, 1, "oreg_rd7");
      op(8'h01, 8'h82, 32'h8282_8282, 8'h30, 1, "oreg_rd1");
      op(8'h80, 8'h83, 32'h8383_8383, 8'h30, 1, "oreg_rd80");
      op(8'h00, 8'h00, 32'h0, 8'h20, 0, "");
      op(8'h00, 8'h00, 32'h0, 8'h20, 0, "");
      op(8'h81, 8'h00, 32'h0, 8'h00, 1, "lat1_again");
      drain();

      chk("scoreboard_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
